// File: rtl/multiplexer_pkg.sv
// Shared select-code definitions for the registered 4:1 multiplexer.
package multiplexer_pkg;

   typedef logic [1:0] sel_t;

   localparam sel_t SEL_A = 2'b00;
   localparam sel_t SEL_B = 2'b01;
   localparam sel_t SEL_C = 2'b10;
   localparam sel_t SEL_D = 2'b11;

endpackage

// File: rtl/multiplexer_mux4_comb.sv
// Pure combinational 4:1 word selection; every bit follows the same select.
module mux4_comb
   import multiplexer_pkg::*;
#(
   parameter int unsigned WIDTH = 1
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [WIDTH-1:0] c_i,
   input  logic [WIDTH-1:0] d_i,
   input  sel_t             sel_i,
   output logic [WIDTH-1:0] y_o
);

   // Decode the select code; an unknown select yields all-X rather than input a.
   always_comb begin
      y_o = 'x;
      case (sel_i)
         SEL_A:   y_o = a_i;
         SEL_B:   y_o = b_i;
         SEL_C:   y_o = c_i;
         SEL_D:   y_o = d_i;
         default: y_o = 'x;
      endcase
   end

endmodule

// File: rtl/multiplexer.sv
// Registered 4:1 multiplexer: one-cycle latency, synchronous active-high reset.
module multiplexer
   import multiplexer_pkg::*;
#(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   input  logic             s0,
   input  logic             s1,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_d;
   logic [WIDTH-1:0] q_q;

   mux4_comb #(
      .WIDTH (WIDTH)
   ) u_mux4_comb (
      .a_i   (a),
      .b_i   (b),
      .c_i   (c),
      .d_i   (d),
      .sel_i ({s1, s0}),
      .y_o   (q_d)
   );

   // Output register; reset wins over the selection sampled on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: tb/tb_multiplexer.sv
// Scoreboard bench for multiplexer at WIDTH=1 and WIDTH=4 driven in lockstep.
module tb_multiplexer;

   logic       clk;
   logic       rst;
   logic       a1, b1, c1, d1;
   logic [3:0] a4, b4, c4, d4;
   logic       s0, s1;
   logic       q1;
   logic [3:0] q4;

   typedef struct {
      logic       q1;
      logic [3:0] q4;
      string      name;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;
   bit   stim_done = 0;

   multiplexer #(.WIDTH(1)) dut1 (
      .clk (clk), .rst (rst), .a (a1), .b (b1), .c (c1), .d (d1),
      .s0 (s0), .s1 (s1), .q (q1)
   );

   multiplexer #(.WIDTH(4)) dut4 (
      .clk (clk), .rst (rst), .a (a4), .b (b4), .c (c4), .d (d4),
      .s0 (s0), .s1 (s1), .q (q4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: select index is s1*2+s0 into the list {a,b,c,d}; reset forces zero.
   function automatic logic [3:0] model(input bit r, input int unsigned idx,
                                        input logic [3:0] in0, input logic [3:0] in1,
                                        input logic [3:0] in2, input logic [3:0] in3);
      logic [3:0] ins[4];
      ins[0] = in0; ins[1] = in1; ins[2] = in2; ins[3] = in3;
      if (r) return 4'h0;
      return ins[idx];
   endfunction

   task automatic drive(input string name, input bit r, input int unsigned sel,
                        input logic [3:0] bits1, input logic [3:0] w0, input logic [3:0] w1,
                        input logic [3:0] w2, input logic [3:0] w3);
      exp_t e;
      logic [3:0] m1;
      @(negedge clk);
      rst = r;
      s1  = sel[1];
      s0  = sel[0];
      a1  = bits1[0]; b1 = bits1[1]; c1 = bits1[2]; d1 = bits1[3];
      a4  = w0; b4 = w1; c4 = w2; d4 = w3;
      m1     = model(r, sel, {3'b0, bits1[0]}, {3'b0, bits1[1]}, {3'b0, bits1[2]},
                     {3'b0, bits1[3]});
      e.q1   = m1[0];
      e.q4   = model(r, sel, w0, w1, w2, w3);
      e.name = name;
      exp_q.push_back(e);
   endtask

   // Monitor: compare after each edge, then confirm q holds between edges.
   initial begin
      exp_t last;
      bit   have_last = 0;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            last = exp_q.pop_front();
            have_last = 1;
            n_cmp++;
            if (q1 !== last.q1) begin
               n_fail++;
               $display("FAIL %s w1: got %0h expected %0h", last.name, q1, last.q1);
            end
            n_cmp++;
            if (q4 !== last.q4) begin
               n_fail++;
               $display("FAIL %s w4: got %0h expected %0h", last.name, q4, last.q4);
            end
         end
         @(negedge clk);
         #1;
         if (have_last) begin
            n_cmp++;
            if (q1 !== last.q1 || q4 !== last.q4) begin
               n_fail++;
               $display("FAIL hold_%s: got %0h/%0h expected %0h/%0h", last.name,
                        q1, q4, last.q1, last.q4);
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      s0 = 1'b0; s1 = 1'b0;
      a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; d1 = 1'b1;
      a4 = 4'hf; b4 = 4'hf; c4 = 4'hf; d4 = 4'hf;

      // Reset with all data high.
      drive("rst0", 1, 0, 4'b1111, 4'hf, 4'hf, 4'hf, 4'hf);
      drive("rst1", 1, 3, 4'b1111, 4'hf, 4'hf, 4'hf, 4'hf);
      // All zeros, select a.
      drive("zero", 0, 0, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0);
      // b=1, d=1 pattern (bits: a,b,c,d = 0,1,0,1), select d.
      drive("sel_d", 0, 3, 4'b1010, 4'h1, 4'h2, 4'h4, 4'h8);
      // Sweep all selects on consecutive edges.
      for (int i = 0; i < 4; i++) drive($sformatf("sweep%0d", i), 0, i, 4'b1010,
                                        4'h1, 4'h2, 4'h4, 4'h8);
      // q=1 via d, then reset while select moves to b, then resume on b.
      drive("pre_rst", 0, 3, 4'b1010, 4'h1, 4'h2, 4'h4, 4'h8);
      drive("mid_rst", 1, 1, 4'b1010, 4'h1, 4'h2, 4'h4, 4'h8);
      drive("resume",  0, 1, 4'b1010, 4'h1, 4'h2, 4'h4, 4'h8);

      // Randomized traffic with occasional reset; data and select change together.
      for (int i = 0; i < 300; i++) begin
         drive("rand", ($urandom_range(0, 15) == 0), $urandom_range(0, 3),
               4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      end

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL drain: %0d entries left expected 0", exp_q.size());
      end
      stim_done = 1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/multiplexer.md
MULTIPLEXER -- requirements
Module: multiplexer

Interface
REQ-001 Parameter WIDTH: default 1; data width of a, b, c, d and q.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 a  input  WIDTH  data input 0, selected when {s1,s0}=00.
REQ-005 b  input  WIDTH  data input 1, selected when {s1,s0}=01.
REQ-006 c  input  WIDTH  data input 2, selected when {s1,s0}=10.
REQ-007 d  input  WIDTH  data input 3, selected when {s1,s0}=11.
REQ-008 s0  input  1  select LSB.
REQ-009 s1  input  1  select MSB.
REQ-010 q  output  WIDTH  registered mux output.

Function
REQ-011 The select code SHALL be {s1,s0}, with s1 as MSB.
REQ-012 Each rising clk edge with rst=0 SHALL load q with the input chosen by the select code sampled on that edge.
REQ-013 Latency SHALL be exactly one clock cycle from input or select change to q.
REQ-014 No handshake: a new selection SHALL be accepted every cycle.
REQ-015 Data inputs and select changing on the same edge SHALL take effect together, using both new values on that edge.
REQ-016 If s0 or s1 is X/Z at a sampling edge, q SHALL become all-X in simulation; no silent default to input a.
REQ-017 For WIDTH>1, every bit of q SHALL come from the same selected input; there is no per-bit selection.
REQ-018 q SHALL hold its value between clock edges; no combinational path from inputs to q.

Reset
REQ-019 When rst=1 at a rising edge, q SHALL become all-zero on that edge.
REQ-020 Reset SHALL take priority over selection on the same edge.
REQ-021 Reset asserted mid-operation SHALL discard the pending selection.
REQ-022 Normal selection SHALL resume on the first edge with rst=0.
REQ-023 Before the first clock edge q is undefined; no initial value is relied upon.

Structure
REQ-024 A shared package SHALL hold the select-code constants SEL_A=2'b00, SEL_B=2'b01, SEL_C=2'b10 and SEL_D=2'b11.
REQ-025 One sub-module, mux4_comb, SHALL hold the pure combinational 4:1 selection.
REQ-026 The top level SHALL hold only the output register and the reset logic.

Verification
REQ-027 rst=1 for 2 cycles with a=b=c=d=1 -> q=0 after each edge.
REQ-028 rst=0; a=0, b=0, c=0, d=0, s1s0=00 -> q=0 one cycle later.
REQ-029 a=0, b=1, c=0, d=1, s1s0=11 -> q=1 (d) one cycle after the edge; q still 0 before that edge.
REQ-030 Same data, sweep s1s0=00,01,10,11 on consecutive edges -> q=0,1,0,1 each lagging one cycle.
REQ-031 q=1 via d, then rst=1 on the same edge that s1s0 changes to 01 -> q=0; next edge with rst=0 -> q=b=1.
REQ-032 WIDTH=4, a=4'h1, b=4'h2, c=4'h4, d=4'h8, all four selects -> q=1,2,4,8 respectively, one cycle later.
